// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared register map, CTRL/STATUS bit positions and FSM
// state type for the LED pattern sequencer.
package led_seq_pkg;

    localparam logic [4:0] REG_CTRL         = 5'd0;
    localparam logic [4:0] REG_PERIOD       = 5'd1;
    localparam logic [4:0] REG_LENGTH       = 5'd2;
    localparam logic [4:0] REG_STATUS       = 5'd3;
    localparam logic [4:0] REG_PATTERN_BASE = 5'd16;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_LOOP   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_IDX_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/led_seq_step_timer.sv
// led_seq_step_timer: loadable down-counter timing one pattern step.
// Ports: clk, rst_n, load_i/load_val_i (reload), en_i (count), expire_o (count==1).
module led_seq_step_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The last counted cycle is the one showing 1, so a period of P
    // spends exactly P cycles waiting.
    assign expire_o = en_i && (cnt_q == DIV_W'(1));

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: Avalon-MM slave holding a pattern table, which it
// replays as Avalon-MM master writes to the LED PIO data register.
// Ports: clk, reset_n; s_* slave (address/chipselect/write_n/writedata/readdata);
// m_* master (address/chipselect/write_n/writedata/waitrequest); irq.
// Define LED_SEQ_DONE_IRQ_EN for a sticky DONE flag and a done interrupt.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int DIV_W     = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        irq
);

    localparam int IW = $clog2(NUM_STEPS);

    seq_state_e       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d, idx_nxt;
    logic [7:0]       wdata_q, wdata_d;
    logic             run_q, run_d, run_eff;
    logic             loop_q, loop_d;
    logic [DIV_W-1:0] period_q, period_d, period_eff;
    logic [4:0]       length_q, length_d, len_eff;
    logic [7:0]       pat_q [NUM_STEPS];

    logic             sw_wr;
    logic             hit_ctrl, hit_period, hit_length, hit_status, hit_pat;
    logic             wr_ctrl, wr_status;
    logic [IW-1:0]    pat_sel;
    logic             last_step;
    logic             tmr_load, tmr_expire;
    logic             fsm_clr_run, fsm_set_done;
    logic             done_rd, irqen_rd;
    logic             busy;
    logic             unused_wdata;

    assign sw_wr      = s_chipselect & ~s_write_n;
    assign hit_ctrl   = (s_address == REG_CTRL);
    assign hit_period = (s_address == REG_PERIOD);
    assign hit_length = (s_address == REG_LENGTH);
    assign hit_status = (s_address == REG_STATUS);
    assign hit_pat    = s_address[4] &&
                        ({1'b0, s_address[3:0]} < 5'(NUM_STEPS));
    assign pat_sel    = s_address[IW-1:0];
    assign wr_ctrl    = sw_wr & hit_ctrl;
    assign wr_status  = sw_wr & hit_status;
    assign unused_wdata = ^s_writedata;

    // A RUN write acts in the same cycle it is presented, so start and
    // stop both take effect on the following clock.
    assign run_eff = wr_ctrl ? s_writedata[CTRL_RUN] : run_q;

    assign len_eff = (length_q == 5'd0)            ? 5'd1 :
                     (length_q > 5'(NUM_STEPS))    ? 5'(NUM_STEPS) :
                                                     length_q;
    assign period_eff = (period_q == '0) ? DIV_W'(1) : period_q;
    assign last_step  = (5'(idx_q) == (len_eff - 5'd1));
    assign idx_nxt    = idx_q + IW'(1);
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                pat_q[i] <= '0;
            end
        end else if (sw_wr && hit_pat) begin
            pat_q[pat_sel] <= s_writedata[7:0];
        end
    end

    always_comb begin
        run_d = run_q;
        if (fsm_clr_run) begin
            run_d = 1'b0;
        end
        if (wr_ctrl) begin
            run_d = s_writedata[CTRL_RUN];
        end
        loop_d   = wr_ctrl ? s_writedata[CTRL_LOOP] : loop_q;
        period_d = (sw_wr && hit_period) ? s_writedata[DIV_W-1:0]
                                         : period_q;
        length_d = (sw_wr && hit_length) ? s_writedata[4:0] : length_q;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        tmr_load     = 1'b0;
        fsm_clr_run  = 1'b0;
        fsm_set_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run_eff) begin
                    state_d = WRITE;
                    idx_d   = '0;
                    wdata_d = pat_q[0];
                end
            end
            WRITE: begin
                // Never abandon a transfer: leave only on acceptance.
                if (!m_waitrequest) begin
                    if (run_eff) begin
                        state_d  = WAIT;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT: begin
                if (!run_eff) begin
                    state_d = IDLE;
                end else if (tmr_expire) begin
                    if (!last_step) begin
                        state_d = WRITE;
                        idx_d   = idx_nxt;
                        wdata_d = pat_q[idx_nxt];
                    end else if (loop_q) begin
                        state_d = WRITE;
                        idx_d   = '0;
                        wdata_d = pat_q[0];
                    end else begin
                        state_d      = IDLE;
                        fsm_clr_run  = 1'b1;
                        fsm_set_done = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wdata_q  <= '0;
            run_q    <= 1'b0;
            loop_q   <= 1'b0;
            period_q <= '0;
            length_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            run_q    <= run_d;
            loop_q   <= loop_d;
            period_q <= period_d;
            length_q <= length_d;
        end
    end

    led_seq_step_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (reset_n),
        .load_i     (tmr_load),
        .load_val_i (period_eff),
        .en_i       (state_q == WAIT),
        .expire_o   (tmr_expire)
    );

`ifdef LED_SEQ_DONE_IRQ_EN
    logic done_q, done_d;
    logic irqen_q, irqen_d;
    logic irq_q;

    // Software clear wins over a same-cycle completion.
    always_comb begin
        done_d = done_q;
        if (fsm_set_done) begin
            done_d = 1'b1;
        end
        if (wr_status && s_writedata[STAT_DONE]) begin
            done_d = 1'b0;
        end
        irqen_d = wr_ctrl ? s_writedata[CTRL_IRQ_EN] : irqen_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q  <= 1'b0;
            irqen_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            done_q  <= done_d;
            irqen_q <= irqen_d;
            irq_q   <= done_q & irqen_q;
        end
    end

    assign done_rd  = done_q;
    assign irqen_rd = irqen_q;
    assign irq      = irq_q;
`else
    logic unused_done;
    assign unused_done = fsm_set_done ^ wr_status;
    assign done_rd     = 1'b0;
    assign irqen_rd    = 1'b0;
    assign irq         = 1'b0;
`endif

    always_comb begin
        s_readdata = '0;
        if (s_chipselect) begin
            unique case (1'b1)
                hit_ctrl: begin
                    s_readdata[CTRL_RUN]    = run_q;
                    s_readdata[CTRL_LOOP]   = loop_q;
                    s_readdata[CTRL_IRQ_EN] = irqen_rd;
                end
                hit_period: s_readdata = 32'(period_q);
                hit_length: s_readdata = 32'(length_q);
                hit_status: begin
                    s_readdata[STAT_BUSY]           = busy;
                    s_readdata[STAT_DONE]           = done_rd;
                    s_readdata[STAT_IDX_LSB +: 4]   = 4'(idx_q);
                end
                hit_pat:  s_readdata = {24'b0, pat_q[pat_sel]};
                default:  s_readdata = '0;
            endcase
        end
    end

    assign m_address    = 2'b00;
    assign m_chipselect = (state_q == WRITE);
    assign m_write_n    = (state_q != WRITE);
    assign m_writedata  = {24'b0, wdata_q};

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: randomized self-checking bench for the LED
// pattern sequencer against a step-list model of the expected PIO writes.
module tb_led_pattern_sequencer;
    import led_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
    logic        irq;

    led_pattern_sequencer #(
        .NUM_STEPS (8),
        .DIV_W     (24)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_chipselect  (s_chipselect),
        .s_write_n     (s_write_n),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: one entry per PIO transfer (first cycle and accept cycle).
    int         st_q[$];
    int         ac_q[$];
    logic [7:0] sd_q[$];
    logic [7:0] ad_q[$];
    bit         in_wr = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_wr <= 1'b0;
        end else if (m_chipselect && !m_write_n) begin
            if (!in_wr) begin
                st_q.push_back(cyc);
                sd_q.push_back(m_writedata[7:0]);
            end
            if (!m_waitrequest) begin
                ac_q.push_back(cyc);
                ad_q.push_back(m_writedata[7:0]);
                in_wr <= 1'b0;
            end else begin
                in_wr <= 1'b1;
            end
        end
    end

    // Waitrequest generator: optional fixed stall on a chosen write,
    // optional random stalls.
    int stall_at = -5;
    int stall_n  = 0;
    bit rnd_ws   = 1'b0;
    bit g_prev   = 1'b0;
    int g_cnt    = 0;

    always @(posedge clk) begin
        #1;
        if (m_chipselect && !m_write_n) begin
            if (g_prev ? (g_cnt > 0) : (cyc == stall_at && stall_n > 0)) begin
                m_waitrequest <= 1'b1;
                g_cnt <= (g_prev ? g_cnt : stall_n) - 1;
            end else begin
                m_waitrequest <= rnd_ws ? ($urandom_range(0, 2) == 0) : 1'b0;
                g_cnt <= 0;
            end
            g_prev <= 1'b1;
        end else begin
            m_waitrequest <= 1'b0;
            g_prev <= 1'b0;
            g_cnt  <= 0;
        end
    end

    logic [7:0] pat_m [8];

    task automatic sw(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        s_address    = a;
        s_writedata  = d;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] d);
        s_chipselect = 1'b1;
        s_write_n    = 1'b1;
        s_address    = a;
        #1;
        d = s_readdata;
        s_chipselect = 1'b0;
    endtask

    task automatic sr(input logic [4:0] a, output logic [31:0] d);
        @(posedge clk);
        #1;
        peek(a, d);
    endtask

    task automatic write_pats();
        for (int i = 0; i < 8; i++) begin
            sw(5'(16 + i), {24'b0, pat_m[i]});
        end
    endtask

    task automatic start_run(input logic [31:0] ctrl, input int stall,
                             output int t0);
        @(posedge clk);
        #1;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        s_address    = REG_CTRL;
        s_writedata  = ctrl;
        t0       = cyc;
        stall_at = cyc + 1;
        stall_n  = stall;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic [31:0] d;
        d = 32'h1;
        for (int i = 0; i < budget; i++) begin
            sr(REG_STATUS, d);
            if (!d[STAT_BUSY]) break;
        end
        chk({tag, ".idle"}, 32'(d[STAT_BUSY]), 32'h0);
    endtask

    // Expected k-th write: pattern k mod length, first one the cycle after
    // RUN, each later one PERIOD+1 cycles after the previous acceptance.
    task automatic check_seq(input string tag, input int base, input int cnt,
                             input int nlen, input int t0, input int peff);
        for (int k = 0; k < cnt && (base + k) < ac_q.size(); k++) begin
            chk($sformatf("%s.d%0d", tag, k), 32'(sd_q[base+k]),
                32'(pat_m[k % nlen]));
            chk($sformatf("%s.h%0d", tag, k), 32'(ad_q[base+k]),
                32'(pat_m[k % nlen]));
            if (k == 0)
                chk($sformatf("%s.t0", tag), 32'(st_q[base]), 32'(t0 + 1));
            else
                chk($sformatf("%s.gap%0d", tag, k),
                    32'(st_q[base+k] - ac_q[base+k-1]), 32'(peff + 1));
        end
    endtask

    task automatic run_once(input string tag, input int len, input int per,
                            input int stall, input bit rws, output int base);
        int t0, n, peff;
        logic [31:0] d;
        n    = (len == 0) ? 1 : ((len > 8) ? 8 : len);
        peff = (per == 0) ? 1 : per;
        rnd_ws = rws;
        sw(REG_PERIOD, 32'(per));
        sw(REG_LENGTH, 32'(len));
        base = ac_q.size();
        start_run(32'h1, stall, t0);
        peek(REG_STATUS, d);
        chk({tag, ".busy"}, 32'(d[STAT_BUSY]), 32'h1);
        wait_idle(tag, 3000);
        chk({tag, ".nwr"}, 32'(ac_q.size() - base), 32'(n));
        check_seq(tag, base, n, n, t0, peff);
        sr(REG_CTRL, d);
        chk({tag, ".run"}, 32'(d[CTRL_RUN]), 32'h0);
        sr(REG_STATUS, d);
        chk({tag, ".idx"}, 32'(d[STAT_IDX_LSB +: 4]), 32'(n - 1));
`ifdef LED_SEQ_DONE_IRQ_EN
        chk({tag, ".done"}, 32'(d[STAT_DONE]), 32'h1);
`else
        chk({tag, ".done"}, 32'(d[STAT_DONE]), 32'h0);
`endif
        rnd_ws = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int base, t0, cnt;

        reset_n      = 1'b0;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_address    = '0;
        s_writedata  = '0;
        #1;
        chk("rst.cs",  32'(m_chipselect), 32'h0);
        chk("rst.wn",  32'(m_write_n), 32'h1);
        chk("rst.wd",  m_writedata, 32'h0);
        chk("rst.ma",  32'(m_address), 32'h0);
        chk("rst.irq", 32'(irq), 32'h0);
        chk("rst.rd",  s_readdata, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        sw(REG_PERIOD, 32'h00ABCDEF);
        sr(REG_PERIOD, d);
        chk("reg.period", d, 32'h00ABCDEF);
        sw(REG_LENGTH, 32'hFFFF_FFFF);
        sr(REG_LENGTH, d);
        chk("reg.length", d, 32'h1F);
        pat_m = '{8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        write_pats();
        sw(5'd24, 32'hFF);
        sr(5'd24, d);
        chk("reg.unmap24", d, 32'h0);
        sr(5'd16, d);
        chk("reg.pat0", d, 32'h01);
        sr(5'd5, d);
        chk("reg.unmap5", d, 32'h0);
        sw(REG_CTRL, 32'h4);
        sr(REG_CTRL, d);
`ifdef LED_SEQ_DONE_IRQ_EN
        chk("reg.irqen", d, 32'h4);
`else
        chk("reg.irqen", d, 32'h0);
`endif
        sw(REG_CTRL, 32'h0);

        run_once("seq3", 3, 4, 0, 1'b0, base);

        run_once("stall", 3, 3, 3, 1'b0, base);
        if (ac_q.size() > base)
            chk("stall.len", 32'(ac_q[base] - st_q[base]), 32'h3);
        else
            chk("stall.len", 32'(ac_q.size()), 32'(base + 1));

        run_once("len0", 0, 0, 0, 1'b0, base);
        sr(REG_PERIOD, d);
        chk("len0.period", d, 32'h0);

        for (int i = 0; i < 8; i++) pat_m[i] = 8'($urandom);
        write_pats();
        run_once("len31", 31, 2, 0, 1'b0, base);

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 8; i++) pat_m[i] = 8'($urandom);
            write_pats();
            run_once($sformatf("rnd%0d", it), $urandom_range(0, 31),
                     $urandom_range(0, 6), 0, 1'b1, base);
        end

        pat_m[0] = 8'hAA;
        pat_m[1] = 8'h55;
        write_pats();
        sw(REG_PERIOD, 32'd4);
        sw(REG_LENGTH, 32'd2);
        base = ac_q.size();
        start_run(32'h3, 0, t0);
        for (int i = 0; i < 200 && ac_q.size() < base + 5; i++)
            @(negedge clk);
        chk("loop.nwr", 32'(ac_q.size() >= base + 5), 32'h1);
        check_seq("loop", base, 5, 2, t0, 4);
        sw(REG_CTRL, 32'h2);
        peek(REG_STATUS, d);
        chk("loop.stop", 32'(d[STAT_BUSY]), 32'h0);
        repeat (30) @(negedge clk);
        cnt = ac_q.size() - base;
        chk("loop.after", 32'(cnt), 32'h5);
        chk("loop.led", m_writedata, 32'hAA);

`ifdef LED_SEQ_DONE_IRQ_EN
        sw(REG_STATUS, 32'h2);
        sw(REG_LENGTH, 32'd1);
        sw(REG_PERIOD, 32'd1);
        start_run(32'h5, 0, t0);
        wait_idle("irq", 100);
        @(posedge clk);
        #1;
        chk("irq.set", 32'(irq), 32'h1);
        sw(REG_STATUS, 32'h2);
        @(posedge clk);
        #1;
        chk("irq.clr", 32'(irq), 32'h0);
        peek(REG_STATUS, d);
        chk("irq.done", 32'(d[STAT_DONE]), 32'h0);
`endif

        for (int i = 0; i < 8; i++) pat_m[i] = 8'($urandom | 1);
        write_pats();
        sw(REG_PERIOD, 32'd6);
        sw(REG_LENGTH, 32'd3);
        base = ac_q.size();
        start_run(32'h3, 0, t0);
        for (int i = 0; i < 200 && ac_q.size() < base + 2; i++)
            @(negedge clk);
        chk("rstw.nwr", 32'(ac_q.size() >= base + 2), 32'h1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rstw.cs",  32'(m_chipselect), 32'h0);
        chk("rstw.wn",  32'(m_write_n), 32'h1);
        chk("rstw.wd",  m_writedata, 32'h0);
        chk("rstw.ma",  32'(m_address), 32'h0);
        chk("rstw.irq", 32'(irq), 32'h0);
        peek(REG_STATUS, d);
        chk("rstw.stat", d, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) pat_m[i] = 8'h00;
        cnt = ac_q.size();
        sr(REG_CTRL, d);
        chk("rstw.ctrl", d, 32'h0);
        sr(5'd16, d);
        chk("rstw.pat0", d, 32'(pat_m[0]));
        repeat (20) @(negedge clk);
        chk("rstw.quiet", 32'(ac_q.size()), 32'(cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
